// File: rtl/modcnt_pkg.sv
// modcnt_pkg: shared types and helpers for the modulo-N counter slice.
//   modcnt_dir_t  - count direction encoding (matches the up_dn pin)
//   modcnt_clamp  - clamp a load value into 0..modulus-1
package modcnt_pkg;

  typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} modcnt_dir_t;

  // Values at or above the modulus land on the top count rather than aliasing.
  function automatic logic [31:0] modcnt_clamp(input logic [31:0] val,
                                               input logic [31:0] modulus);
    return (val < modulus) ? val : (modulus - 32'd1);
  endfunction

endpackage

// File: rtl/modcnt_next.sv
// modcnt_next: combinational successor of a modulo-N count value.
//   q       in   WIDTH  current count
//   dir     in   1      count direction
//   q_next  out  WIDTH  modulo successor of q in direction dir
//   at_term out  1      q sits on the terminal value for dir (MODULUS-1 up, 0 down)
module modcnt_next
  import modcnt_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic [WIDTH-1:0] q,
  input  modcnt_dir_t      dir,
  output logic [WIDTH-1:0] q_next,
  output logic             at_term
);

  // One extra bit so MODULUS == 2**WIDTH needs no natural overflow.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 1);

  logic [WIDTH:0] q_ext;
  logic [WIDTH:0] inc;
  logic [WIDTH:0] dec;

  always_comb begin
    q_ext   = {1'b0, q};
    inc     = q_ext + (WIDTH+1)'(1);
    dec     = q_ext - (WIDTH+1)'(1);
    at_term = 1'b0;
    q_next  = q;
    if (dir == DIR_UP) begin
      at_term = (inc == MOD_EXT);
      q_next  = at_term ? '0 : inc[WIDTH-1:0];
    end else begin
      at_term = (q_ext == '0);
      q_next  = at_term ? MAX_Q : dec[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/param_mod_counter.sv
// param_mod_counter: parametrised modulo-N up/down counter with load,
// terminal count and wrap pulse.
//   clk       in   1      rising-edge clock
//   reset     in   1      synchronous active-low reset
//   en        in   1      count enable
//   up_dn     in   1      1 = up, 0 = down
//   load      in   1      parallel load strobe (beats en)
//   load_val  in   WIDTH  load value, clamped to MODULUS-1
//   q         out  WIDTH  registered count
//   tc        out  1      combinational terminal count (for cascading)
//   wrap      out  1      registered one-cycle wrap/saturation pulse
// Build option: MODCNT_SATURATE_EN makes the counter stop at its limits
// instead of wrapping; wrap then flags the first blocked step only.
module param_mod_counter
  import modcnt_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MODULUS   = 16,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  if (WIDTH < 1) begin : g_bad_width
    $error("param_mod_counter: WIDTH must be >= 1");
  end
  if (MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_mod
    $error("param_mod_counter: MODULUS must be in 2..2**WIDTH");
  end
  if (RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_rst
    $error("param_mod_counter: RESET_VAL must be < MODULUS");
  end

  localparam logic [WIDTH-1:0] RESET_Q = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] q_next;
  logic             at_term;
  modcnt_dir_t      dir;

  assign dir = modcnt_dir_t'(up_dn);

  modcnt_next #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_next (
    .q       (q_q),
    .dir     (dir),
    .q_next  (q_next),
    .at_term (at_term)
  );

`ifdef MODCNT_SATURATE_EN
  // Set once a step has been blocked at a limit; suppresses repeat pulses.
  logic sat_hit_q, sat_hit_d;
`endif

  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
`ifdef MODCNT_SATURATE_EN
    sat_hit_d = sat_hit_q;
`endif
    if (load) begin
      q_d = WIDTH'(modcnt_clamp(32'(load_val), 32'(MODULUS)));
`ifdef MODCNT_SATURATE_EN
      sat_hit_d = 1'b0;
`endif
    end else if (en) begin
`ifdef MODCNT_SATURATE_EN
      if (at_term) begin
        wrap_d    = ~sat_hit_q;
        sat_hit_d = 1'b1;
      end else begin
        q_d       = q_next;
        sat_hit_d = 1'b0;
      end
`else
      q_d    = q_next;
      wrap_d = at_term;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      q_q    <= RESET_Q;
      wrap_q <= 1'b0;
`ifdef MODCNT_SATURATE_EN
      sat_hit_q <= 1'b0;
`endif
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
`ifdef MODCNT_SATURATE_EN
      sat_hit_q <= sat_hit_d;
`endif
    end
  end

  assign q    = q_q;
  assign wrap = wrap_q;
  assign tc   = en & at_term;

endmodule

// File: tb/tb_param_mod_counter.sv
module tb_param_mod_counter;

  localparam int WIDTH     = 4;
  localparam int MODULUS   = 10;
  localparam int RESET_VAL = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             en = 1'b0;
  logic             up_dn = 1'b1;
  logic             load = 1'b0;
  logic [WIDTH-1:0] load_val = '0;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             wrap;

  param_mod_counter #(
    .WIDTH     (WIDTH),
    .MODULUS   (MODULUS),
    .RESET_VAL (RESET_VAL)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .up_dn    (up_dn),
    .load     (load),
    .load_val (load_val),
    .q        (q),
    .tc       (tc),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    q;
    bit    wrap;
    bit    tc;
    string tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   stim_done = 1'b0;

  // Reference model state: plain integers, driven by the counter's rules.
  int m_q       = 0;
  bit m_blocked = 1'b0;

  // Drive one cycle of inputs at the falling edge, advance the model
  // across the next rising edge and queue what the outputs should show.
  task automatic step(input bit rst_n, input bit ld, input int lv,
                      input bit e, input bit ud, input string tag);
    exp_t x;
    bit   w;
    @(negedge clk);
    reset    = rst_n;
    load     = ld;
    load_val = WIDTH'(lv);
    en       = e;
    up_dn    = ud;
    w = 1'b0;
    if (!rst_n) begin
      m_q = RESET_VAL;
      m_blocked = 1'b0;
    end else if (ld) begin
      m_q = (lv < MODULUS) ? lv : MODULUS - 1;
      m_blocked = 1'b0;
    end else if (e) begin
      bit at_lim;
      at_lim = ud ? (m_q == MODULUS - 1) : (m_q == 0);
`ifdef MODCNT_SATURATE_EN
      if (at_lim) begin
        w = !m_blocked;
        m_blocked = 1'b1;
      end else begin
        m_q = ud ? m_q + 1 : m_q - 1;
        m_blocked = 1'b0;
      end
`else
      w = at_lim;
      m_q = ud ? (m_q + 1) % MODULUS : (m_q + MODULUS - 1) % MODULUS;
`endif
    end
    x.q    = m_q;
    x.wrap = w;
    x.tc   = e && (ud ? (m_q == MODULUS - 1) : (m_q == 0));
    x.tag  = tag;
    exp_q.push_back(x);
  endtask

  // Monitor: outputs are valid every cycle, sampled 1 time unit after the edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t x;
        x = exp_q.pop_front();
        n_tests++;
        if (q !== WIDTH'(x.q)) begin
          n_fail++;
          $display("FAIL %s q: got %0d expected %0d", x.tag, q, x.q);
        end
        n_tests++;
        if (wrap !== x.wrap) begin
          n_fail++;
          $display("FAIL %s wrap: got %b expected %b", x.tag, wrap, x.wrap);
        end
        n_tests++;
        if (tc !== x.tc) begin
          n_fail++;
          $display("FAIL %s tc: got %b expected %b", x.tag, tc, x.tc);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 1: reset held two cycles with en high, then the first count.
    step(0, 0, 0, 1, 1, "reset0");
    step(0, 0, 0, 1, 1, "reset1");
    step(1, 0, 0, 1, 1, "post_reset");

    // 2: full up sweep through the wrap.
    step(1, 1, 0, 0, 1, "load0");
    for (int i = 0; i < 11; i++) step(1, 0, 0, 1, 1, "up_sweep");
    step(1, 0, 0, 0, 1, "hold_after_wrap");

    // 3: load clamp, then down wrap from 0.
    step(1, 1, 12, 0, 1, "load_clamp");
    step(1, 1, 0, 0, 0, "load0_dn");
    step(1, 0, 0, 1, 0, "down_wrap");
    step(1, 0, 0, 1, 0, "down_step");

    // 4: priority.
    step(1, 1, 5, 1, 1, "load_over_en");
    step(0, 1, 7, 1, 1, "reset_over_load");

    // 5: mid-run reset.
    step(1, 1, 7, 0, 1, "load7");
    step(1, 0, 0, 1, 1, "up_to8");
    step(0, 0, 0, 1, 1, "mid_reset");
    step(1, 0, 0, 1, 1, "resume");

    // 6: limit behaviour near the top and at zero.
    step(1, 1, 8, 0, 1, "load8");
    for (int i = 0; i < 4; i++) step(1, 0, 0, 1, 1, "top_run");
    step(1, 0, 0, 1, 0, "turn_down");
    step(1, 1, 0, 0, 0, "load_zero");
    step(1, 0, 0, 1, 0, "bottom0");
    step(1, 0, 0, 1, 0, "bottom1");
    step(1, 0, 0, 0, 0, "hold_bottom");
    step(1, 0, 0, 1, 0, "bottom2");
    step(1, 0, 0, 1, 1, "leave_bottom");

    // Direction toggling at the limits.
    step(1, 1, 9, 0, 1, "load9");
    for (int i = 0; i < 6; i++) step(1, 0, 0, 1, i[0], "toggle");

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      bit r, l, e, u;
      int v;
      r = ($urandom_range(0, 39) != 0);
      l = ($urandom_range(0, 7) == 0);
      e = ($urandom_range(0, 3) != 0);
      u = $urandom_range(0, 1) == 1;
      v = $urandom_range(0, (1 << WIDTH) - 1);
      step(r, l, v, e, u, "random");
    end

    stim_done = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
